// File: rtl/conv_out_stage.sv
// Output stage of the convolution pipeline: drops pipeline-fill sums, clips the
// surviving sums to 8-bit pixels and buffers them in a small FIFO with a frame-end tag.
module conv_out_stage #(
  parameter int IMG_W = 12,
  parameter int IMG_H = 5,
  parameter int KSIZE = 5,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [16:0] in_sum,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_last,
  output logic               frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } ent_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fd_q, fd_d;
  ent_t          mem_q [DEPTH];

  logic          full, accept, pop, push, col_end, row_end;
  logic [7:0]    clip;
  ent_t          wr_ent, head;

  always_comb begin
    full      = (cnt_q == (AW+1)'(DEPTH));
    // reset gates in_ready directly so it reads 0 the whole time reset is held
    in_ready  = reset & ~full;
    out_valid = (cnt_q != '0);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
    col_end   = (col_q == CW'(IMG_W-1));
    row_end   = (row_q == RW'(IMG_H-1));
    push      = accept && (int'(col_q) >= KSIZE-1) && (int'(row_q) >= KSIZE-1);

    if (in_sum < 17'sd0)        clip = 8'd0;
    else if (in_sum > 17'sd255) clip = 8'd255;
    else                        clip = in_sum[7:0];
    wr_ent.data = clip;
    wr_ent.last = row_end & col_end;

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) row_d = row_end ? '0 : row_q + 1'b1;
    end
    fd_d = accept & row_end & col_end;

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    head       = mem_q[rptr_q];
    out_data   = out_valid ? head.data : 8'd0;
    out_last   = out_valid & head.last;
    frame_done = fd_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      fd_q   <= fd_d;
    end
  end

  // Storage needs no reset: the occupancy count masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_ent;
  end

endmodule

// File: tb/tb_conv_out_stage.sv
// Randomized scoreboard bench for conv_out_stage against a frame-position reference model.
module tb_conv_out_stage;

  localparam int IMG_W = 12;
  localparam int IMG_H = 5;
  localparam int KSIZE = 5;
  localparam int DEPTH = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [16:0] in_sum = '0;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         out_data;
  logic               out_last;
  logic               frame_done;

  conv_out_stage #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(KSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   mcnt = 0, idx = 0;
  bit   fd_exp = 1'b0, in_rst = 1'b1, tog = 1'b0;
  int   n_pop = 0, n_last = 0, n_fd = 0;
  int   clip_vals[6] = '{-1, -65536, 0, 255, 256, 65535};

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clip_ref(input int s);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // One clock of stimulus; the model advances on the same edge the DUT does.
  task automatic step(input int vm, input int rm, input int dm);
    int s, c, r;
    bit acc, pop, push;
    exp_t e;
    case (vm)
      0:       in_valid = 1'b0;
      1:       in_valid = 1'b1;
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    case (rm)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: begin tog = ~tog; out_ready = tog; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    case (dm)
      0:       s = idx;
      1:       s = clip_vals[$urandom_range(0, 5)];
      default: s = int'($urandom_range(0, 131071)) - 65536;
    endcase
    in_sum = s[16:0];
    @(posedge clk);
    acc  = in_valid && (mcnt < DEPTH);
    pop  = (mcnt > 0) && out_ready;
    push = 1'b0;
    fd_exp = 1'b0;
    if (acc) begin
      c = idx % IMG_W;
      r = idx / IMG_W;
      if (c >= KSIZE-1 && r >= KSIZE-1) begin
        e.data = clip_ref(s);
        e.last = (idx == NPIX-1);
        exp_q.push_back(e);
        push = 1'b1;
      end
      fd_exp = (idx == NPIX-1);
      idx = (idx + 1) % NPIX;
    end
    mcnt = mcnt + int'(push) - int'(pop);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (mcnt > 0 && n < 50) begin step(0, 1, 0); n++; end
    step(0, 1, 0);
    step(0, 1, 0);
    chk("drain_empty", int'(out_valid), 0);
  endtask

  task automatic finish_frame(input int dm);
    int n = 0;
    while (idx != 0 && n < 300) begin step(1, 1, dm); n++; end
    chk("frame_complete_ready", int'(in_ready), 1);
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    mcnt = 0;
    idx = 0;
    fd_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ready", int'(in_ready), 0);
    reset = 1'b1;
    #1;
    chk("rst_release_ready", int'(in_ready), 1);
    in_rst = 1'b0;
  endtask

  task automatic clr_counts();
    n_pop = 0; n_last = 0; n_fd = 0;
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each consumer handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        chk("in_ready", int'(in_ready), int'(mcnt < DEPTH));
        chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
        chk("frame_done", int'(frame_done), int'(fd_exp));
        if (frame_done) n_fd++;
        if (exp_q.size() != 0) begin
          chk("out_data", int'(out_data), exp_q[0].data);
          chk("out_last", int'(out_last), int'(exp_q[0].last));
          if (out_ready) begin
            if (exp_q[0].last) n_last++;
            void'(exp_q.pop_front());
            n_pop++;
          end
        end else begin
          chk("idle_data", int'(out_data), 0);
          chk("idle_last", int'(out_last), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // single indexed frame, consumer always ready
    clr_counts();
    repeat (NPIX) step(1, 1, 0);
    drain();
    chk("frame_pops", n_pop, 8);
    chk("frame_lasts", n_last, 1);
    chk("frame_done_pulses", n_fd, 1);

    // clip boundaries
    clr_counts();
    repeat (NPIX) step(1, 1, 1);
    drain();
    chk("clip_pops", n_pop, 8);

    // consumer stalled for a whole frame, then released
    clr_counts();
    repeat (NPIX) step(1, 0, 0);
    chk("stall_ready", int'(in_ready), 0);
    chk("stall_valid", int'(out_valid), 1);
    finish_frame(0);
    drain();
    chk("stall_pops", n_pop, 8);
    chk("stall_lasts", n_last, 1);

    // consumer toggling every cycle
    clr_counts();
    repeat (NPIX) step(1, 2, 0);
    finish_frame(0);
    drain();
    chk("toggle_pops", n_pop, 8);
    chk("toggle_done", n_fd, 1);

    // reset mid-frame with entries buffered
    repeat (54) step(1, 0, 0);
    chk("pre_rst_valid", int'(out_valid), 1);
    do_reset();
    clr_counts();
    repeat (NPIX) step(1, 1, 0);
    drain();
    chk("post_rst_pops", n_pop, 8);
    chk("post_rst_lasts", n_last, 1);

    // two back-to-back frames
    clr_counts();
    repeat (2 * NPIX) step(1, 1, 0);
    drain();
    chk("b2b_pops", n_pop, 16);
    chk("b2b_lasts", n_last, 2);
    chk("b2b_done", n_fd, 2);

    // fully random traffic
    repeat (500) step(2, 3, 2);
    finish_frame(2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_out_stage.md
CONV_OUT_STAGE -- requirements
Module: conv_out_stage

Interface
REQ-001 Parameter IMG_W, default 12, meaning pixels per image row.
REQ-002 Parameter IMG_H, default 5, meaning rows per frame.
REQ-003 Parameter KSIZE, default 5, meaning kernel width/height; first KSIZE-1 columns and rows of each frame are pipeline-fill sums.
REQ-004 Parameter DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_sum carries a convolution row sum this cycle.
REQ-008 in_sum  input  17  signed accumulator from the shift-row stage.
REQ-009 in_ready  output  1  stage can accept a sample this cycle.
REQ-010 out_valid  output  1  out_data/out_last hold a valid FIFO head.
REQ-011 out_ready  input  1  consumer takes the head this cycle.
REQ-012 out_data  output  8  clipped unsigned output pixel.
REQ-013 out_last  output  1  head is the final kept pixel of the frame.
REQ-014 frame_done  output  1  one-cycle pulse after the final input sample of a frame is accepted.

Function
REQ-015 Acceptance SHALL occur at a rising edge where in_valid=1 and in_ready=1; no other state change is caused by in_sum.
REQ-016 in_ready SHALL equal NOT fifo_full, computed from the current occupancy only (a same-cycle pop does not free space).
REQ-017 Column counter col SHALL count 0..IMG_W-1 per accepted sample and wrap to 0; row counter row SHALL increment on col wrap, counting 0..IMG_H-1, and wrap to 0.
REQ-018 An accepted sample SHALL be kept iff col >= KSIZE-1 and row >= KSIZE-1 (counter values before the increment); discarded samples only advance counters.
REQ-019 Clip SHALL be: in_sum < 0 -> 0; in_sum > 255 -> 255; otherwise in_sum[7:0]; comparison signed on full 17 bits.
REQ-020 Kept sample SHALL be written to the FIFO with last tag = (row==IMG_H-1 and col==IMG_W-1).
REQ-021 Latency: a kept sample accepted at edge k into an empty FIFO SHALL appear with out_valid=1 after edge k (same cycle as its write becomes visible), i.e. first observable in cycle k+1.
REQ-022 Pop SHALL occur at an edge where out_valid=1 and out_ready=1; out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; at occupancy 1 the pushed entry becomes head next cycle.
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy counter range 0..DEPTH; no overflow or underflow possible by REQ-016/REQ-022.
REQ-025 frame_done SHALL be 1 for exactly the cycle following acceptance of row=IMG_H-1, col=IMG_W-1, independent of keep status and FIFO state.
REQ-026 out_valid=0 SHALL force out_data and out_last to 0.

Reset
REQ-027 On reset low, immediately and without clk: col=0, row=0, FIFO empty, in_ready=0, out_valid=0, out_data=0, out_last=0, frame_done=0.
REQ-028 While reset is low in_ready SHALL stay 0; after reset rises in_ready SHALL be 1 at the first cycle.
REQ-029 Reset mid-frame SHALL discard all FIFO contents and counters; the next accepted sample is col 0, row 0 of a new frame.

Verification
REQ-030 Defaults, 60 samples in_sum = index (0..59), out_ready=1 -> exactly 8 outputs, values 52..59, out_last only on 59, frame_done one pulse after sample 59.
REQ-031 Clip: kept positions fed -1, -65536, 0, 255, 256, 65535 -> outputs 0, 0, 0, 255, 255, 255.
REQ-032 out_ready=0 for whole frame -> 4 outputs buffered, in_ready drops after 4th kept sample, input stalls; releasing out_ready drains 52,53,54,55 then resumes in order, no loss.
REQ-033 out_ready toggling every cycle with continuous in_valid -> output sequence identical to REQ-030, out_data stable while stalled.
REQ-034 Assert reset low at sample 55 with 2 entries in FIFO -> out_valid=0 immediately; following 60-sample frame yields REQ-030 result.
REQ-035 Two back-to-back frames -> 16 outputs, two out_last, two frame_done pulses, counters wrap with no idle cycle.
